active_list_retire: RTL and testbench
=====================================

ACTIVE_LIST_RETIRE -- requirements
Module: active_list_retire

Interface
REQ-001 Parameter DEPTH, default 32, active-list entries (power of two); TAG_W = log2(DEPTH).
REQ-002 Parameter PHYS_W, default 6, physical register index width; ARCH_W fixed at 5.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 disp_valid  in  1  renamer presents one renamed instruction.
REQ-006 disp_ready  out  1  entry accepted when disp_valid & disp_ready.
REQ-007 disp_uses_rw  in  1  instruction writes an architectural register.
REQ-008 disp_arch_rd  in  5  architectural destination.
REQ-009 disp_new_phys / disp_old_phys  in  PHYS_W each  newly allocated / previously mapped physical register.
REQ-010 disp_is_branch  in  1  branch or jump.
REQ-011 disp_tag  out  TAG_W  index the accepted entry occupies (current tail).
REQ-012 cmp_valid  in  1  execution completion; cmp_tag  in  TAG_W  entry; cmp_mispredict  in  1  branch resolved wrong.
REQ-013 free_valid  out  1  return free_phys (out, PHYS_W) to the free list this cycle.
REQ-014 retire_valid  out  1  committed write; retire_arch_rd (out, 5), retire_phys (out, PHYS_W) update the committed map.
REQ-015 squash  out  1  rollback in progress; flush_done  out  1  one-cycle pulse at rollback end.

Function
REQ-016 Circular buffer; entry = {valid, done, mispred, uses_rw, arch_rd, new_phys, old_phys, is_branch}; head/tail TAG_W bits wrap DEPTH-1 -> 0; count TAG_W+1 bits.
REQ-017 disp_ready = (count < DEPTH) & state==RUN; accepted entry written at tail with done=0, tail+1.
REQ-018 Completion with valid entry sets done, mispred = cmp_mispredict & is_branch; completion to invalid entry or during ROLLBACK ignored.
REQ-019 Retire at most one entry per cycle, in order: head valid & done in RUN -> head clears, head+1.
REQ-020 Retirement outputs registered: retire in cycle N -> retire_valid/free_valid in N+1, one cycle wide.
REQ-021 Retired entry with uses_rw: free_valid=1, free_phys=old_phys, retire_valid=1, retire_arch_rd=arch_rd, retire_phys=new_phys; without uses_rw: all three outputs 0.
REQ-022 Completion written cycle N makes head eligible in N+1 (no same-cycle bypass).
REQ-023 Dispatch and retire in same cycle: both take effect, count unchanged.
REQ-024 States RUN, ROLLBACK; retiring head with mispred=1 -> ROLLBACK next cycle, walk pointer = tail-1.
REQ-025 ROLLBACK: one entry per cycle from tail-1 toward head; if uses_rw, free_valid=1, free_phys=new_phys; entry invalidated; squash=1 throughout.
REQ-026 Walk reaches head (all younger squashed, including zero entries) -> flush_done=1 for one cycle, tail=head, count=0, state RUN.
REQ-027 Dispatch during ROLLBACK refused (disp_ready=0); free_valid never asserted twice for one phys in one cycle.

Reset
REQ-028 rst_n low: head=tail=count=0, all entries invalid, state RUN, free_valid=retire_valid=squash=flush_done=0, disp_ready=1 after release.
REQ-029 Reset mid-ROLLBACK abandons walk; no flush_done issued.

Structure
REQ-030 DEPTH, PHYS_W, active-list entry struct and state enum live in shared package mips_core_pkg.
REQ-031 Single module; no sub-modules; storage as register array.

Verification
REQ-032 Dispatch 3 (rd 2/3/4, new 40/41/42, old 2/3/4), complete tags 2,0,1 -> retire order rd 2,3,4; free_phys 2,3,4 on consecutive cycles.
REQ-033 Dispatch 32 without completion -> disp_ready=0, 33rd ignored; complete tag 0 -> disp_ready=1 two cycles later.
REQ-034 Branch at tag 5 mispredicted, tags 6-8 write new 50,51,52 -> squash, free_phys 52,51,50, flush_done, tail=6.
REQ-035 Tail wraps 31->0 with head 30: retire through 31 and 0 in order, count correct.
REQ-036 Mispredicted branch as youngest entry -> flush_done one cycle after ROLLBACK entry, no free_valid.
REQ-037 rst_n asserted during ROLLBACK -> all outputs 0 immediately, no flush_done.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared core types: active-list geometry, entry layout and retire-FSM states.
// Every active-list stage that stores entries imports this package.
package mips_core_pkg;

    localparam int AL_DEPTH  = 32;
    localparam int AL_PHYS_W = 6;
    localparam int AL_ARCH_W = 5;
    localparam int AL_TAG_W  = $clog2(AL_DEPTH);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_ROLLBACK = 1'b1
    } al_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 done;
        logic                 mispred;
        logic                 uses_rw;
        logic [AL_ARCH_W-1:0] arch_rd;
        logic [AL_PHYS_W-1:0] new_phys;
        logic [AL_PHYS_W-1:0] old_phys;
        logic                 is_branch;
    } al_entry_t;

endpackage

// File: rtl/active_list_retire.sv
// In-order active list: accepts renamed instructions, retires completed heads,
// and rolls back younger entries after a mispredicted branch retires.
//
//  state       | meaning
//  ------------+---------------------------------------------------------------
//  ST_RUN      | dispatch, completion and in-order retirement enabled
//  ST_ROLLBACK | squashing one entry per cycle from tail-1 back to head
module active_list_retire
    import mips_core_pkg::*;
#(
    parameter int DEPTH  = AL_DEPTH,
    parameter int PHYS_W = AL_PHYS_W,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_disp_valid,
    output logic              o_disp_ready,
    input  logic              i_disp_uses_rw,
    input  logic [4:0]        i_disp_arch_rd,
    input  logic [PHYS_W-1:0] i_disp_new_phys,
    input  logic [PHYS_W-1:0] i_disp_old_phys,
    input  logic              i_disp_is_branch,
    output logic [TAG_W-1:0]  o_disp_tag,
    input  logic              i_cmp_valid,
    input  logic [TAG_W-1:0]  i_cmp_tag,
    input  logic              i_cmp_mispredict,
    output logic              o_free_valid,
    output logic [PHYS_W-1:0] o_free_phys,
    output logic              o_retire_valid,
    output logic [4:0]        o_retire_arch_rd,
    output logic [PHYS_W-1:0] o_retire_phys,
    output logic              o_squash,
    output logic              o_flush_done
);

    localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

    // Entry layout comes from the package, so PHYS_W must equal AL_PHYS_W.
    al_entry_t         r_entries [DEPTH];
    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;
    al_state_e         r_state;
    al_state_e         w_state_next;

    logic              r_free_valid;
    logic [PHYS_W-1:0] r_free_phys;
    logic              r_retire_valid;
    logic [4:0]        r_retire_arch_rd;
    logic [PHYS_W-1:0] r_retire_phys;
    logic              r_flush_done;

    al_entry_t         w_head_entry;
    al_entry_t         w_walk_entry;
    al_entry_t         w_new_entry;
    logic [TAG_W-1:0]  w_walk;
    logic              w_disp;
    logic              w_retire;
    logic              w_rb_step;
    logic              w_rb_end;
    logic              w_cmp_hit;
    logic [TAG_W:0]    w_count_next;

    assign w_head_entry = r_entries[r_head];
    assign w_walk       = r_tail - TAG_W'(1);
    assign w_walk_entry = r_entries[w_walk];

    assign o_disp_ready = rst_n && (r_count < FULL) && (r_state == ST_RUN);
    assign w_disp       = i_disp_valid && o_disp_ready;
    assign w_retire     = (r_state == ST_RUN) && w_head_entry.valid && w_head_entry.done;
    assign w_rb_step    = (r_state == ST_ROLLBACK) && (r_count != '0);
    assign w_rb_end     = (r_state == ST_ROLLBACK) && (r_count == '0);
    assign w_cmp_hit    = i_cmp_valid && (r_state == ST_RUN) && r_entries[i_cmp_tag].valid;

    always_comb begin
        w_new_entry           = '0;
        w_new_entry.valid     = 1'b1;
        w_new_entry.uses_rw   = i_disp_uses_rw;
        w_new_entry.arch_rd   = i_disp_arch_rd;
        w_new_entry.new_phys  = i_disp_new_phys;
        w_new_entry.old_phys  = i_disp_old_phys;
        w_new_entry.is_branch = i_disp_is_branch;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:      if (w_retire && w_head_entry.mispred) w_state_next = ST_ROLLBACK;
            ST_ROLLBACK: if (w_rb_end) w_state_next = ST_RUN;
            default:     w_state_next = ST_RUN;
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        if (w_rb_step) begin
            w_count_next = r_count - (TAG_W+1)'(1);
        end else if (w_disp && !w_retire) begin
            w_count_next = r_count + (TAG_W+1)'(1);
        end else if (!w_disp && w_retire) begin
            w_count_next = r_count - (TAG_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            r_free_valid     <= 1'b0;
            r_free_phys      <= '0;
            r_retire_valid   <= 1'b0;
            r_retire_arch_rd <= '0;
            r_retire_phys    <= '0;
            r_flush_done     <= 1'b0;
        end else begin
            r_free_valid     <= 1'b0;
            r_free_phys      <= '0;
            r_retire_valid   <= 1'b0;
            r_retire_arch_rd <= '0;
            r_retire_phys    <= '0;
            r_flush_done     <= w_rb_end;
            r_count          <= w_count_next;

            if (w_cmp_hit) begin
                r_entries[i_cmp_tag].done    <= 1'b1;
                r_entries[i_cmp_tag].mispred <= i_cmp_mispredict && r_entries[i_cmp_tag].is_branch;
            end

            if (w_disp) begin
                r_entries[r_tail] <= w_new_entry;
                r_tail            <= r_tail + TAG_W'(1);
            end

            if (w_retire) begin
                r_entries[r_head] <= '0;
                r_head            <= r_head + TAG_W'(1);
                if (w_head_entry.uses_rw) begin
                    r_free_valid     <= 1'b1;
                    r_free_phys      <= w_head_entry.old_phys;
                    r_retire_valid   <= 1'b1;
                    r_retire_arch_rd <= w_head_entry.arch_rd;
                    r_retire_phys    <= w_head_entry.new_phys;
                end
            end

            // Squashed entries hand back the register they were allocated.
            if (w_rb_step) begin
                r_entries[w_walk] <= '0;
                r_tail            <= w_walk;
                if (w_walk_entry.uses_rw) begin
                    r_free_valid <= 1'b1;
                    r_free_phys  <= w_walk_entry.new_phys;
                end
            end
        end
    end

    assign o_disp_tag       = r_tail;
    assign o_free_valid     = r_free_valid;
    assign o_free_phys      = r_free_phys;
    assign o_retire_valid   = r_retire_valid;
    assign o_retire_arch_rd = r_retire_arch_rd;
    assign o_retire_phys    = r_retire_phys;
    assign o_squash         = (r_state == ST_ROLLBACK);
    assign o_flush_done     = r_flush_done;

endmodule

// File: tb/tb_active_list_retire.sv
// Directed bench for active_list_retire: a scoreboard of expected free/retire
// events is filled at dispatch and drained by a negedge monitor.
module tb_active_list_retire;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_disp_valid = 1'b0;
    logic       o_disp_ready;
    logic       i_disp_uses_rw = 1'b0;
    logic [4:0] i_disp_arch_rd = '0;
    logic [5:0] i_disp_new_phys = '0;
    logic [5:0] i_disp_old_phys = '0;
    logic       i_disp_is_branch = 1'b0;
    logic [4:0] o_disp_tag;
    logic       i_cmp_valid = 1'b0;
    logic [4:0] i_cmp_tag = '0;
    logic       i_cmp_mispredict = 1'b0;
    logic       o_free_valid;
    logic [5:0] o_free_phys;
    logic       o_retire_valid;
    logic [4:0] o_retire_arch_rd;
    logic [5:0] o_retire_phys;
    logic       o_squash;
    logic       o_flush_done;

    typedef struct {
        logic [4:0] rd;
        logic [5:0] phys;
    } ret_t;

    logic [5:0] exp_free[$];
    ret_t       exp_ret_q[$];
    int         checks = 0;
    int         failures = 0;
    int         n_flush = 0;
    logic [4:0] m_tail = '0;

    active_list_retire dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_disp_valid     (i_disp_valid),
        .o_disp_ready     (o_disp_ready),
        .i_disp_uses_rw   (i_disp_uses_rw),
        .i_disp_arch_rd   (i_disp_arch_rd),
        .i_disp_new_phys  (i_disp_new_phys),
        .i_disp_old_phys  (i_disp_old_phys),
        .i_disp_is_branch (i_disp_is_branch),
        .o_disp_tag       (o_disp_tag),
        .i_cmp_valid      (i_cmp_valid),
        .i_cmp_tag        (i_cmp_tag),
        .i_cmp_mispredict (i_cmp_mispredict),
        .o_free_valid     (o_free_valid),
        .o_free_phys      (o_free_phys),
        .o_retire_valid   (o_retire_valid),
        .o_retire_arch_rd (o_retire_arch_rd),
        .o_retire_phys    (o_retire_phys),
        .o_squash         (o_squash),
        .o_flush_done     (o_flush_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops one expectation per observed output event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_free.size() == 0) begin
                check("free_idle", o_free_valid, 1'b0);
            end else if (o_free_valid) begin
                check("free_phys", o_free_phys, exp_free.pop_front());
            end
            if (exp_ret_q.size() == 0) begin
                check("retire_idle", o_retire_valid, 1'b0);
            end else if (o_retire_valid) begin
                ret_t r;
                r = exp_ret_q.pop_front();
                check("retire_rd", o_retire_arch_rd, r.rd);
                check("retire_phys", o_retire_phys, r.phys);
            end
            if (o_flush_done) n_flush++;
        end
    end

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        i_disp_valid = 1'b0;
        i_cmp_valid = 1'b0;
        #1;
        check("rst_squash", o_squash, 1'b0);
        check("rst_free", o_free_valid, 1'b0);
        check("rst_retire", o_retire_valid, 1'b0);
        check("rst_flush", o_flush_done, 1'b0);
        check("rst_ready", o_disp_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("rst_ready_rel", o_disp_ready, 1'b1);
        check("rst_tag", o_disp_tag, 5'd0);
        m_tail = '0;
    endtask

    task automatic dispatch(input logic uses, input logic [4:0] rd, input logic [5:0] np,
                            input logic [5:0] op, input logic br, input logic exp_retire);
        i_disp_valid     = 1'b1;
        i_disp_uses_rw   = uses;
        i_disp_arch_rd   = rd;
        i_disp_new_phys  = np;
        i_disp_old_phys  = op;
        i_disp_is_branch = br;
        check("disp_ready", o_disp_ready, 1'b1);
        check("disp_tag", o_disp_tag, m_tail);
        if (exp_retire && uses) begin
            exp_free.push_back(op);
            exp_ret_q.push_back('{rd: rd, phys: np});
        end
        m_tail = m_tail + 5'd1;
        tick();
        i_disp_valid = 1'b0;
    endtask

    task automatic complete(input logic [4:0] tag, input logic mp);
        i_cmp_valid      = 1'b1;
        i_cmp_tag        = tag;
        i_cmp_mispredict = mp;
        tick();
        i_cmp_valid      = 1'b0;
        i_cmp_mispredict = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_free.size() != 0 || exp_ret_q.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        check("drain", exp_free.size() + exp_ret_q.size(), 0);
    endtask

    initial begin
        int sq;
        int fl;
        int first;
        int flc;
        int w;

        do_reset();

        // Out-of-order completion, in-order retirement on consecutive cycles.
        dispatch(1, 5'd2, 6'd40, 6'd2, 0, 1);
        dispatch(1, 5'd3, 6'd41, 6'd3, 0, 1);
        dispatch(1, 5'd4, 6'd42, 6'd4, 0, 1);
        complete(5'd2, 0);
        complete(5'd0, 0);
        complete(5'd1, 0);
        check("ooo_free0_v", o_free_valid, 1'b1);
        check("ooo_free0", o_free_phys, 6'd2);
        tick();
        check("ooo_free1_v", o_free_valid, 1'b1);
        check("ooo_free1", o_free_phys, 6'd3);
        tick();
        check("ooo_free2_v", o_free_valid, 1'b1);
        check("ooo_free2", o_free_phys, 6'd4);
        tick();
        check("ooo_free_end", o_free_valid, 1'b0);
        wait_drain();

        // Full list refuses the 33rd entry; one retirement reopens dispatch.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            dispatch(1, 5'(i), 6'(i + 20), 6'(i), 0, 1);
        end
        i_disp_valid    = 1'b1;
        i_disp_uses_rw  = 1'b1;
        i_disp_arch_rd  = 5'd31;
        i_disp_new_phys = 6'd63;
        i_disp_old_phys = 6'd63;
        check("full_ready", o_disp_ready, 1'b0);
        tick();
        i_disp_valid = 1'b0;
        complete(5'd0, 0);
        check("full_ready_n1", o_disp_ready, 1'b0);
        tick();
        check("full_ready_n2", o_disp_ready, 1'b1);
        for (int i = 1; i < 32; i++) begin
            complete(5'(i), 0);
        end
        wait_drain();
        check("full_tag_wrap", o_disp_tag, 5'd0);

        // Tail wrap with head at 30, then confirm occupancy via refill.
        do_reset();
        for (int i = 0; i < 30; i++) dispatch(0, 5'd0, 6'd0, 6'd0, 0, 0);
        for (int i = 0; i < 30; i++) complete(5'(i), 0);
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            dispatch(1, 5'(10 + i), 6'(20 + i), 6'(30 + i), 0, 1);
        end
        complete(5'd1, 0);
        complete(5'd0, 0);
        complete(5'd31, 0);
        complete(5'd30, 0);
        wait_drain();
        check("wrap_tag", o_disp_tag, 5'd2);
        for (int i = 0; i < 32; i++) dispatch(0, 5'd0, 6'd0, 6'd0, 0, 0);
        check("wrap_full", o_disp_ready, 1'b0);

        // Mispredicted branch at tag 5 with three younger writers.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            dispatch(1, 5'(i + 1), 6'(30 + i), 6'(i + 1), 0, 1);
        end
        dispatch(0, 5'd0, 6'd0, 6'd0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            dispatch(1, 5'(7 + i), 6'(50 + i), 6'(10 + i), 0, 0);
        end
        exp_free.push_back(6'd52);
        exp_free.push_back(6'd51);
        exp_free.push_back(6'd50);
        for (int i = 0; i < 5; i++) complete(5'(i), 0);
        complete(5'd6, 0);
        complete(5'd5, 1);
        sq = 0;
        fl = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (o_squash) begin
                sq++;
                check("rb_ready", o_disp_ready, 1'b0);
            end
            if (o_flush_done) fl++;
        end
        check("rb_squash_cycles", sq, 4);
        check("rb_flush_pulses", fl, 1);
        check("rb_tail", o_disp_tag, 5'd6);
        wait_drain();
        m_tail = 5'd6;
        dispatch(1, 5'd5, 6'd60, 6'd61, 0, 1);
        complete(5'd7, 0);
        complete(5'd6, 0);
        wait_drain();

        // Mispredicted branch as youngest entry: immediate flush, no frees.
        do_reset();
        dispatch(1, 5'd1, 6'd33, 6'd34, 0, 1);
        dispatch(0, 5'd0, 6'd0, 6'd0, 1, 0);
        complete(5'd0, 0);
        complete(5'd1, 1);
        first = -1;
        flc = -1;
        sq = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (o_squash && first < 0) first = c;
            if (o_squash) sq++;
            if (o_flush_done) flc = c;
        end
        check("young_flush_gap", flc - first, 1);
        check("young_squash_cycles", sq, 1);
        check("young_tag", o_disp_tag, 5'd2);
        wait_drain();

        // Reset during rollback abandons the walk.
        do_reset();
        dispatch(0, 5'd0, 6'd0, 6'd0, 1, 0);
        for (int i = 0; i < 3; i++) dispatch(1, 5'(i + 1), 6'(44 + i), 6'(i + 1), 0, 0);
        complete(5'd0, 1);
        w = 0;
        while (!o_squash && w < 20) begin
            tick();
            w++;
        end
        check("rst_rb_enter", o_squash, 1'b1);
        do_reset();
        repeat (10) tick();
        check("flush_count", n_flush, 2);
        check("post_rst_ready", o_disp_ready, 1'b1);
        check("post_rst_tag", o_disp_tag, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
